seven_segment_reader: RTL and testbench
=======================================

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning cycles {an,seg} must stay unchanged before a digit is sampled (legal 2..255).
REQ-002 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port seg  input  7  multiplexed segment bus, active-low, bit6=g down to bit0=a.
REQ-005 SHALL have port an  input  4  digit enables, active-low; an[i]=0 selects digit i.
REQ-006 SHALL have port digits  output  16  captured frame; nibble i (bits 4i+3:4i) = value of digit i.
REQ-007 SHALL have port blank  output  4  per-digit flag: captured pattern was 7'b1111111.
REQ-008 SHALL have port err  output  4  per-digit flag: captured pattern not legal.
REQ-009 SHALL have port out_valid  output  1  frame available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts frame.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL decode digits 0..9 from patterns 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000.
REQ-013 SHALL decode 1111111 as value 0 with blank=1, err=0; any other pattern as value 0 with err=1, blank=0.
REQ-014 SHALL register {an,seg} once and count consecutive unchanged cycles; any change reloads count to 0.
REQ-015 SHALL sample exactly once per dwell, in the cycle count reaches STABLE_CYCLES-1, only if an is one-hot-low.
REQ-016 SHALL ignore an=4'b1111 and any multi-zero an value (no capture, no error).
REQ-017 SHALL store each sample into working slot i and set working mask bit i; re-capturing an already-set slot overwrites it.
REQ-018 SHALL, when mask becomes 4'b1111, copy working slots to digits/blank/err, set out_valid the next cycle, and clear mask the same cycle.
REQ-019 SHALL hold digits/blank/err stable while out_valid=1; transfer completes on out_valid&&out_ready, dropping out_valid next cycle.
REQ-020 SHALL, if a frame completes while out_valid=1 and out_ready=0, discard it, keep old outputs, and pulse overrun.
REQ-021 SHALL, if frame completion coincides with out_valid&&out_ready, load the new frame and keep out_valid=1.
REQ-022 SHALL keep collecting during out_valid (working slots are a second buffer).
REQ-023 SHALL use states COLLECT (out_valid=0) and PRESENT (out_valid=1); COLLECT->PRESENT on frame complete, PRESENT->COLLECT on handshake without new frame.

Reset
REQ-024 SHALL on rst_n=0 immediately clear digits, blank, err, out_valid, overrun, mask, stability count, and sampled {an,seg} to an=4'b1111, seg=7'b1111111.
REQ-025 SHALL discard any partial frame when reset asserts mid-collection; first frame after release needs four fresh captures.

Configuration
REQ-026 SHALL, with SEVEN_SEGMENT_READER_HEX_EN defined, additionally decode A=0001000,b=0000011,C=1000110,d=0100001,E=0000110,F=0001110 to 10..15 with err=0.
REQ-027 SHALL, without SEVEN_SEGMENT_READER_HEX_EN, flag those six patterns as err=1, value 0.

Structure
REQ-028 SHALL place the 7-bit pattern constants, BLANK constant, and state enum in package seven_segment_pkg, shared with the existing segment decoder.
REQ-029 SHALL implement pattern-to-value mapping as sub-module seven_segment_pattern_decode (combinational, 7 in, value/blank/err out).

Verification
REQ-030 SHALL test: scan 1,2,3,4 on an 1110,1101,1011,0111, 4 cycles each, out_ready=1 -> digits=16'h4321, blank=0, err=0, one out_valid cycle.
REQ-031 SHALL test: digit 2 held 3 cycles then changed (STABLE_CYCLES=4) -> no capture of digit 2, frame not completed.
REQ-032 SHALL test: digit 0 = 1111111, digit 1 = 1111110 -> blank=4'b0001, err=4'b0010.
REQ-033 SHALL test: out_ready=0, two full frames -> first frame held, overrun pulses once, out_valid stays 1.
REQ-034 SHALL test: seg=0001000 on digit 3 -> nibble 3=4'hA err=0 with HEX_EN; err[3]=1 without.
REQ-035 SHALL test: rst_n low after 2 captures -> all outputs 0 asynchronously; after release, 4 new captures needed for out_valid.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment blocks: active-low segment
// patterns (bit6=g .. bit0=a), the blank pattern, the per-digit capture
// record and the reader's output state machine encoding.
package seven_segment_pkg;

  localparam int DIGIT_N = 4;
  localparam int SEG_W   = 7;

  localparam logic [SEG_W-1:0] PAT_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] PAT_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] PAT_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] PAT_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] PAT_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] PAT_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] PAT_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] PAT_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] PAT_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] PAT_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] PAT_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] PAT_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] PAT_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] PAT_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] PAT_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] PAT_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] PAT_BLANK = 7'b1111111;

  // One captured digit: decoded value plus its classification flags.
  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
  } digit_t;

  // COLLECT: no frame offered; PRESENT: out_valid asserted.
  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational segment-pattern decoder: 7-bit active-low pattern to a
// 4-bit value with blank/err flags. Hex letters A..F are recognised only
// when SEVEN_SEGMENT_READER_HEX_EN is defined; otherwise they flag err.
module seven_segment_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       value,
  output logic             blank,
  output logic             err
);

  // Map a pattern to its digit value; unknown patterns report err.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    value = 4'd0;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      PAT_0:     value = 4'd0;
      PAT_1:     value = 4'd1;
      PAT_2:     value = 4'd2;
      PAT_3:     value = 4'd3;
      PAT_4:     value = 4'd4;
      PAT_5:     value = 4'd5;
      PAT_6:     value = 4'd6;
      PAT_7:     value = 4'd7;
      PAT_8:     value = 4'd8;
      PAT_9:     value = 4'd9;
      PAT_BLANK: blank = 1'b1;
`ifdef SEVEN_SEGMENT_READER_HEX_EN
      PAT_A:     value = 4'd10;
      PAT_B:     value = 4'd11;
      PAT_C:     value = 4'd12;
      PAT_D:     value = 4'd13;
      PAT_E:     value = 4'd14;
      PAT_F:     value = 4'd15;
`endif
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Seven-segment bus reader: watches a multiplexed, active-low {an,seg}
// display bus, samples each digit once it has dwelt STABLE_CYCLES cycles,
// assembles four digits into a frame and offers it with a valid/ready
// handshake. A frame completing while the previous one is still unaccepted
// is dropped and reported on overrun.
// Optional: define SEVEN_SEGMENT_READER_HEX_EN to decode hex letters A..F.
module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEG_W-1:0]     seg,
  input  logic [DIGIT_N-1:0]   an,
  output logic [4*DIGIT_N-1:0] digits,
  output logic [DIGIT_N-1:0]   blank,
  output logic [DIGIT_N-1:0]   err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  // Sample fires when the count reads SAMPLE_AT; the count then parks at
  // STOP_AT so a long dwell yields exactly one capture.
  localparam logic [7:0] SAMPLE_AT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] STOP_AT   = 8'(STABLE_CYCLES);

  logic [DIGIT_N-1:0] an_q;
  logic [SEG_W-1:0]   seg_q;
  logic [7:0]         count_q;
  logic               changed;

  logic               sel_valid;
  logic [1:0]         sel_idx;
  logic               capture;
  logic [DIGIT_N-1:0] cap_mask;
  logic [DIGIT_N-1:0] mask_q;
  logic               frame_done;

  digit_t             dec;
  digit_t             slot_q [DIGIT_N];
  digit_t             frame  [DIGIT_N];
  logic [4*DIGIT_N-1:0] frame_digits;
  logic [DIGIT_N-1:0]   frame_blank;
  logic [DIGIT_N-1:0]   frame_err;

  state_t             state_q;
  state_t             state_d;
  logic               load;
  logic               drop;

  assign changed = ({an, seg} != {an_q, seg_q});

  // Register the bus once and count how long it has stayed unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      an_q    <= '1;
      seg_q   <= PAT_BLANK;
      count_q <= '0;
    end else if (changed) begin
      an_q    <= an;
      seg_q   <= seg;
      count_q <= '0;
    end else if (count_q != STOP_AT) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Identify the selected digit; idle and multi-select values are ignored.
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (an_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  assign capture    = sel_valid && (count_q == SAMPLE_AT);
  assign cap_mask   = capture ? (4'b0001 << sel_idx) : 4'b0000;
  assign frame_done = capture && ((mask_q | cap_mask) == 4'b1111);

  seven_segment_pattern_decode u_decode (
    .pattern (seg_q),
    .value   (dec.value),
    .blank   (dec.blank),
    .err     (dec.err)
  );

  // Working buffer: store each captured digit in its slot.
  always_ff @(posedge clk) begin
    // NOTE: slot contents need no reset; mask_q alone decides which slots
    // are meaningful, and it is cleared by reset.
    if (capture) slot_q[sel_idx] <= dec;
  end

  // Track which slots hold a capture for the frame being assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mask_q <= '0;
    else if (frame_done) mask_q <= '0;
    else                 mask_q <= mask_q | cap_mask;
  end

  // Assemble the completed frame, bypassing the digit captured this cycle.
  always_comb begin
    frame_digits = '0;
    frame_blank  = '0;
    frame_err    = '0;
    for (int i = 0; i < DIGIT_N; i++) begin
      frame[i] = (capture && (sel_idx == 2'(i))) ? dec : slot_q[i];
      frame_digits[4*i +: 4] = frame[i].value;
      frame_blank[i]         = frame[i].blank;
      frame_err[i]           = frame[i].err;
    end
  end

  // Output state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next state: load a new frame unless one is still waiting unaccepted.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (frame_done) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (frame_done) begin
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Presented frame and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits  <= '0;
      blank   <= '0;
      err     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= drop;
      if (load) begin
        digits <= frame_digits;
        blank  <= frame_blank;
        err    <= frame_err;
      end
    end
  end

  assign out_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader (STABLE_CYCLES = 4).
// Expectations for hex patterns follow SEVEN_SEGMENT_READER_HEX_EN.
module tb_seven_segment_reader;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SBL = 7'b1111111;
  localparam logic [6:0] SBAD = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int vld_cnt = 0;

  typedef struct {
    string            name;
    logic [3:0][6:0]  pat;
    logic [15:0]      digits;
    logic [3:0]       blank;
    logic [3:0]       err;
  } vec_t;

  vec_t vecs [6];

  seven_segment_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .digits    (digits),
    .blank     (blank),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Count overrun pulses and out_valid cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (overrun === 1'b1)   ovr_cnt++;
    if (out_valid === 1'b1) vld_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present {a,s} for n rising edges; returns 1 time unit after the last.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(4'b1111, SBL, n);
  endtask

  // Scan digits 0..3 in order, four cycles each.
  task automatic scan4(input logic [3:0][6:0] p);
    logic [3:0] sel;
    for (int d = 0; d < 4; d++) begin
      sel = 4'b0001 << d;
      hold(~sel, p[d], 4);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3,
                              input logic [15:0] d, input logic [3:0] b, input logic [3:0] e);
    vec_t v;
    v.name   = n;
    v.pat    = {p3, p2, p1, p0};
    v.digits = d;
    v.blank  = b;
    v.err    = e;
    return v;
  endfunction

  initial begin
    int snap;

    vecs[0] = mk("scan_1234", S1, S2, S3, S4, 16'h4321, 4'b0000, 4'b0000);
    vecs[1] = mk("scan_5678", S5, S6, S7, S8, 16'h8765, 4'b0000, 4'b0000);
    vecs[2] = mk("mix_9_0_bl_bad", S9, S0, SBL, SBAD, 16'h0009, 4'b0100, 4'b1000);
    vecs[3] = mk("blank0_err1", SBL, SBAD, S2, S3, 16'h3200, 4'b0001, 4'b0010);
`ifdef SEVEN_SEGMENT_READER_HEX_EN
    vecs[4] = mk("hex_A_digit3", S0, S1, S2, SA, 16'hA210, 4'b0000, 4'b0000);
    vecs[5] = mk("hex_bCdE", SB, SC, SD, SE, 16'hEDCB, 4'b0000, 4'b0000);
`else
    vecs[4] = mk("hex_A_digit3", S0, S1, S2, SA, 16'h0210, 4'b0000, 4'b1000);
    vecs[5] = mk("hex_bCdE", SB, SC, SD, SE, 16'h0000, 4'b0000, 4'b1111);
`endif

    // Reset state
    rst_n = 1'b0;
    an = 4'b1111;
    seg = SBL;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_digits", digits, 16'h0000);
    check("reset_blank_err", {blank, err}, 8'h00);
    check("reset_overrun", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames with immediate acceptance
    foreach (vecs[i]) begin
      scan4(vecs[i].pat);
      snap = vld_cnt;
      idle(1);
      check({vecs[i].name, "_valid"}, out_valid, 1'b1);
      check({vecs[i].name, "_digits"}, digits, vecs[i].digits);
      check({vecs[i].name, "_blank"}, blank, vecs[i].blank);
      check({vecs[i].name, "_err"}, err, vecs[i].err);
      idle(2);
      check({vecs[i].name, "_valid_cycles"}, vld_cnt - snap, 1);
    end

    // Digit 2 dwells only 3 cycles: no capture, frame stays incomplete
    hold(4'b1110, S0, 4);
    hold(4'b1101, S1, 4);
    hold(4'b1011, S5, 3);
    hold(4'b0111, S4, 4);
    idle(6);
    check("short_dwell_no_frame", out_valid, 1'b0);
    hold(4'b1011, S7, 4);
    idle(1);
    check("short_dwell_completed_valid", out_valid, 1'b1);
    check("short_dwell_completed_digits", digits, 16'h4710);
    idle(1);

    // Overrun: consumer stalls across two full frames
    out_ready = 1'b0;
    scan4({S4, S3, S2, S1});
    idle(1);
    check("stall_first_valid", out_valid, 1'b1);
    check("stall_first_digits", digits, 16'h4321);
    snap = ovr_cnt;
    scan4({S8, S7, S6, S5});
    idle(1);
    check("stall_overrun_pulse", overrun, 1'b1);
    check("stall_digits_held", digits, 16'h4321);
    idle(1);
    check("stall_overrun_cleared", overrun, 1'b0);
    check("stall_valid_held", out_valid, 1'b1);
    idle(3);
    check("stall_overrun_count", ovr_cnt - snap, 1);
    out_ready = 1'b1;
    idle(1);
    check("stall_released_valid", out_valid, 1'b0);

    // New frame coincides with the handshake of the presented one
    out_ready = 1'b0;
    scan4({S6, S7, S8, S9});
    idle(1);
    check("coincide_first_digits", digits, 16'h6789);
    scan4({S3, S2, S1, S0});
    out_ready = 1'b1;
    snap = ovr_cnt;
    idle(1);
    check("coincide_valid_kept", out_valid, 1'b1);
    check("coincide_new_digits", digits, 16'h3210);
    idle(1);
    check("coincide_then_collect", out_valid, 1'b0);
    check("coincide_no_overrun", ovr_cnt - snap, 0);

    // Asynchronous reset mid-collection discards the partial frame
    out_ready = 1'b0;
    scan4({S4, SBAD, SBL, S1});
    idle(1);
    check("prereset_digits", {digits, blank, err}, {16'h4001, 4'b0010, 4'b0100});
    hold(4'b1110, S5, 4);
    hold(4'b1101, S6, 4);
    hold(4'b1011, S7, 2);
    #2;
    rst_n = 1'b0;
    an = 4'b1111;
    seg = SBL;
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_outputs", {digits, blank, err, overrun}, 25'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    hold(4'b1011, S8, 4);
    hold(4'b0111, S9, 4);
    idle(6);
    check("post_reset_partial", out_valid, 1'b0);
    hold(4'b1110, S1, 4);
    hold(4'b1101, S2, 4);
    idle(1);
    check("post_reset_valid", out_valid, 1'b1);
    check("post_reset_digits", digits, 16'h9821);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
